dmem_responder: RTL
===================

Name: dmem_responder

Overview:
Memory-side responder for the core's data-memory port. It accepts one load/store request at a time over a valid/ready request channel and holds it for a programmable access latency. It then returns read data or a write acknowledge over a valid/ready response channel. It replaces the zero-latency data memory so that cores and bus masters that stall on memory can be exercised.

Parameters:
DEPTH, 256, number of 32-bit words in the backing array (power of two, >=4)
LATENCY, 2, cycles from request acceptance to rsp_valid assertion (1..15)

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  1  initiator presents a request
req_ready  output  1  responder can accept a request this cycle
req_we  input  1  1 = store, 0 = load
req_addr  input  32  byte address
req_wdata  input  32  store data
req_be  input  4  byte enables for stores; bit i enables byte i (bits 8i+7:8i)
rsp_valid  output  1  response available
rsp_ready  input  1  initiator accepts response
rsp_rdata  output  32  load data; 0 for stores and errors
rsp_we  output  1  echo of req_we of the request being answered
rsp_err  output  1  request was misaligned or out of range

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, port name reset.
- On reset:
  - state=IDLE.
  - rsp_valid=0, rsp_rdata=0, rsp_we=0, rsp_err=0.
  - Latency counter=0.
  - req_ready=1 in the first cycle after reset deasserts.
  - Array contents are not cleared.
- States: IDLE, WAIT, RESP.
- req_ready: combinational, =1 only in IDLE. Must not depend on req_valid.
- Accept: req_valid & req_ready at a rising edge.
  - Word index = req_addr[log2(DEPTH)+1:2].
  - err = (req_addr[1:0]!=0) | (req_addr[31:log2(DEPTH)+2]!=0).
- At the accept edge:
  - Store, no error: commit each byte with req_be[i]=1; other bytes unchanged.
  - Load, no error: capture array word into the response register.
  - Error: array untouched; rdata captured as 0.
  - rsp_we and rsp_err are latched.
- State transitions:
  - IDLE -> WAIT if LATENCY>1, counter loaded with LATENCY-2.
  - IDLE -> RESP if LATENCY==1.
  - WAIT: counter decrements each cycle; at 0 -> RESP.
  - Result: rsp_valid rises exactly LATENCY cycles after the accept edge.
- RESP:
  - rsp_valid=1. rsp_rdata, rsp_we and rsp_err held stable until rsp_valid & rsp_ready.
  - On the handshake -> IDLE; rsp_valid=0 the next cycle.
  - No new request is accepted in the handshake cycle. Minimum period is LATENCY+1 cycles per request.
- Input changes while not IDLE are ignored. Only the values latched at acceptance are used.
- Store with req_be=0: no array change, normal ack, rsp_err=0.
- rsp_ready held low: stays in RESP indefinitely; outputs stable.
- rsp_ready high before rsp_valid: no effect.
- Reset mid-operation (WAIT or RESP):
  - The request is abandoned and no response is produced.
  - A store already committed at acceptance remains in the array.
- Loads: rsp_rdata is the full word; byte/half extraction is the initiator's job. req_be is ignored for loads.
- Loads return the word value at the accept edge, including any store from an earlier, completed request.

Decomposition:
- Shared package dmem_pkg:
  - state enum dmem_state_t {IDLE, WAIT, RESP}.
  - WORD_BYTES=4, BE_W=4, ADDR_W=32.
  - Function is_misaligned(addr).
- Sub-module dmem_array:
  - Synchronous-write, combinational-read word RAM with 4-bit byte-enable write.
  - Ports: clk, we, be, widx, wdata, ridx, rdata.
  - The responder FSM, counter and response registers stay in dmem_responder.

Test Plan:
- Store then load (LATENCY=2): store addr 0x10, wdata 0xDEADBEEF, be=4'hF; then load 0x10.
  - Store: rsp_valid 2 cycles after accept, rsp_we=1, rsp_err=0, rsp_rdata=0.
  - Load: rsp_rdata=0xDEADBEEF.
- Byte enables: store 0x10, wdata 0x11223344, be=4'b0101; then load 0x10 -> rsp_rdata=0xDE22BE44.
- Misaligned: load 0x13 -> rsp_err=1, rsp_rdata=0. Store 0x13 -> rsp_err=1; a later load 0x10 is unchanged.
- Out of range (DEPTH=256): store 0x400 -> rsp_err=1; load 0x000 unaffected.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid.
  - rsp_valid and rsp_rdata stable; req_ready=0 throughout.
  - After the handshake, req_ready=1 the next cycle.
- LATENCY=1 back-to-back with rsp_ready=1:
  - Requests accepted every 2 cycles.
  - Reset asserted while in WAIT (LATENCY=4) -> rsp_valid never rises; req_ready=1 after reset.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder slice.
// Holds the FSM state encoding, bus widths and the alignment check.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    localparam int WORD_BYTES = 4;
    localparam int BE_W       = 4;
    localparam int ADDR_W     = 32;

    function automatic logic is_misaligned(input logic [ADDR_W-1:0] addr);
        return (addr & ADDR_W'(WORD_BYTES - 1)) != '0;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-wide backing store: synchronous byte-enabled write, combinational read.
// Contents are deliberately not reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [BE_W-1:0]           be,
    input  logic [IDX_W-1:0]          widx,
    input  logic [8*WORD_BYTES-1:0]   wdata,
    input  logic [IDX_W-1:0]          ridx,
    output logic [8*WORD_BYTES-1:0]   rdata
);

    logic [8*WORD_BYTES-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be[i]) begin
                    mem[widx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[ridx];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store, waits LATENCY cycles, then
// presents the read data or write acknowledge until the initiator takes it.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_we,
    output logic              rsp_err
);

    localparam int         IDX_W    = $clog2(DEPTH);
    // The WAIT state itself accounts for one cycle, the RESP entry for another.
    localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    dmem_state_t       state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              we_q, we_d;
    logic              err_q, err_d;

    logic [IDX_W-1:0]  idx;
    logic              range_err;
    logic              addr_err;
    logic              accept;
    logic              mem_we;
    logic [31:0]       mem_rdata;

    assign idx       = req_addr[IDX_W+1:2];
    assign range_err = |req_addr[ADDR_W-1:IDX_W+2];
    assign addr_err  = is_misaligned(req_addr) | range_err;
    assign req_ready = (state_q == IDLE);
    assign accept    = req_valid & req_ready;
    assign mem_we    = accept & req_we & ~addr_err;

    dmem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .be    (req_be),
        .widx  (idx),
        .wdata (req_wdata),
        .ridx  (idx),
        .rdata (mem_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        we_d    = we_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    rdata_d = (req_we || addr_err) ? 32'h0 : mem_rdata;
                    we_d    = req_we;
                    err_d   = addr_err;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'h0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            we_q    <= we_d;
            err_q   <= err_d;
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_we    = we_q;
    assign rsp_err   = err_q;

endmodule
